// File: rtl/operand_bank_if.sv
`default_nettype none
// ============================================================================
//  Module  : operand_bank_if
//  Brief   : Load/done handshake and parallel operand bus between the input
//            front end (master) and the operand_bank (slave).
//  Rev     : 1.0  initial release
// ============================================================================
interface operand_bank_if #(
    parameter int N       = 4,
    parameter int NUM_OPS = 2
);
    localparam int CW = $clog2(NUM_OPS + 1);

    logic                 load;
    logic                 done;
    logic [N-1:0]         in;
    logic                 ready;
    logic [NUM_OPS*N-1:0] reg_out;
    logic                 loaded;
    logic [CW-1:0]        count;
    logic                 err_ovf;

    modport master (
        output load,
        output done,
        output in,
        input  ready,
        input  reg_out,
        input  loaded,
        input  count,
        input  err_ovf
    );

    modport slave (
        input  load,
        input  done,
        input  in,
        output ready,
        output reg_out,
        output loaded,
        output count,
        output err_ovf
    );
endinterface
`default_nettype wire

// File: rtl/operand_bank.sv
`default_nettype none
// ============================================================================
//  Module  : operand_bank
//  Brief   : Captures NUM_OPS operands of N bits, one per accepted load, and
//            holds the full set until the consumer pulses done.
//            Optional macro OPERAND_BANK_CLR_ON_DONE_EN zeroes all slots when
//            done releases a held set.
//  Rev     : 1.0  initial release
// ============================================================================
module operand_bank #(
    parameter int N       = 4,
    parameter int NUM_OPS = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    operand_bank_if.slave bank
);
    localparam int CW = $clog2(NUM_OPS + 1);

    localparam logic [0:0]    S_FILL   = 1'b0;
    localparam logic [0:0]    S_HOLD   = 1'b1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPS - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          err_ovf_q;
    logic          err_ovf_d;
    logic [N-1:0]  slot_q [NUM_OPS];

    logic          w_in_fill;
    logic          w_in_hold;
    logic          w_wr_en;
    logic [CW-1:0] w_wr_idx;
`ifdef OPERAND_BANK_CLR_ON_DONE_EN
    logic          w_clr;
`endif

    assign w_in_fill = (state_q == S_FILL);
    assign w_in_hold = (state_q == S_HOLD);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL: begin
                if (bank.load) begin
                    if (bank.done) begin
                        // done restarts the set; a single-slot bank is full at once
                        state_d = (NUM_OPS == 1) ? S_HOLD : S_FILL;
                    end else if (count_q == LAST_IDX) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bank.done && !(bank.load && (NUM_OPS == 1))) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath control: slot writes, operand count, overflow flag
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_en   = bank.load && (w_in_fill || bank.done);
        w_wr_idx  = bank.done ? '0 : count_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q | (w_in_hold & bank.load & ~bank.done);
        if (bank.done) begin
            count_d = bank.load ? ONE_CNT : '0;
        end else if (w_in_fill && bank.load) begin
            count_d = count_q + ONE_CNT;
        end
    end

`ifdef OPERAND_BANK_CLR_ON_DONE_EN
    assign w_clr = w_in_hold && bank.done;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // A simultaneous load into slot 0 wins over the release clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_OPS; k++) begin
            if (rst) begin
                slot_q[k] <= '0;
            end else if (w_wr_en && (w_wr_idx == CW'(k))) begin
                slot_q[k] <= bank.in;
`ifdef OPERAND_BANK_CLR_ON_DONE_EN
            end else if (w_clr) begin
                slot_q[k] <= '0;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bank.ready   = w_in_fill;
        bank.loaded  = w_in_hold;
        bank.count   = count_q;
        bank.err_ovf = err_ovf_q;
        bank.reg_out = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            bank.reg_out[k*N +: N] = slot_q[k];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_operand_bank.sv
`default_nettype none
// ============================================================================
//  Module  : tb_operand_bank
//  Brief   : Directed self-checking bench: a 3x4-bit bank and a 1x8-bit bank.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_operand_bank;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    operand_bank_if #(.N(4), .NUM_OPS(3)) bus_a ();
    operand_bank_if #(.N(8), .NUM_OPS(1)) bus_b ();

    operand_bank #(.N(4), .NUM_OPS(3)) u_bank_a (
        .clk  (clk),
        .rst  (rst),
        .bank (bus_a)
    );

    operand_bank #(.N(8), .NUM_OPS(1)) u_bank_b (
        .clk  (clk),
        .rst  (rst),
        .bank (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic ld, input logic dn, input logic [3:0] d);
        bus_a.load = ld;
        bus_a.done = dn;
        bus_a.in   = d;
        @(posedge clk);
        #1;
        bus_a.load = 1'b0;
        bus_a.done = 1'b0;
    endtask

    task automatic step_b(input logic ld, input logic dn, input logic [7:0] d);
        bus_b.load = ld;
        bus_b.done = dn;
        bus_b.in   = d;
        @(posedge clk);
        #1;
        bus_b.load = 1'b0;
        bus_b.done = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        bus_a.load = 1'b0;
        bus_a.done = 1'b0;
        bus_a.in   = '0;
        bus_b.load = 1'b0;
        bus_b.done = 1'b0;
        bus_b.in   = '0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_count",   32'(bus_a.count),   32'd0);
        check("rst_loaded",  32'(bus_a.loaded),  32'd0);
        check("rst_err",     32'(bus_a.err_ovf), 32'd0);
        check("rst_regout",  32'(bus_a.reg_out), 32'h000);
        check("rst_ready",   32'(bus_a.ready),   32'd1);
        check("rst_b_ready", 32'(bus_b.ready),   32'd1);

        // Fill A, 5, 3
        step_a(1'b1, 1'b0, 4'hA);
        check("s1_count1", 32'(bus_a.count), 32'd1);
        check("s1_ready1", 32'(bus_a.ready), 32'd1);
        step_a(1'b1, 1'b0, 4'h5);
        check("s1_count2",  32'(bus_a.count),  32'd2);
        check("s1_loaded2", 32'(bus_a.loaded), 32'd0);
        check("s1_ready2",  32'(bus_a.ready),  32'd1);
        step_a(1'b1, 1'b0, 4'h3);
        check("s1_count3",  32'(bus_a.count),   32'd3);
        check("s1_loaded3", 32'(bus_a.loaded),  32'd1);
        check("s1_regout",  32'(bus_a.reg_out), 32'h35A);
        check("s1_ready3",  32'(bus_a.ready),   32'd0);

        // Overflow while full
        step_a(1'b1, 1'b0, 4'hF);
        check("s2_regout", 32'(bus_a.reg_out), 32'h35A);
        check("s2_err",    32'(bus_a.err_ovf), 32'd1);
        check("s2_count",  32'(bus_a.count),   32'd3);
        check("s2_loaded", 32'(bus_a.loaded),  32'd1);

        // Back-to-back reuse: done with load of 7
        step_a(1'b1, 1'b1, 4'h7);
        check("s3_loaded", 32'(bus_a.loaded),  32'd0);
        check("s3_count",  32'(bus_a.count),   32'd1);
        check("s3_ready",  32'(bus_a.ready),   32'd1);
        check("s3_err",    32'(bus_a.err_ovf), 32'd1);
`ifdef OPERAND_BANK_CLR_ON_DONE_EN
        check("s3_regout", 32'(bus_a.reg_out), 32'h007);
`else
        check("s3_regout", 32'(bus_a.reg_out), 32'h357);
`endif

        // Flush from FILL, partial fill, flush, fresh set
        step_a(1'b0, 1'b1, 4'h0);
        check("s4_flush0", 32'(bus_a.count), 32'd0);
        step_a(1'b1, 1'b0, 4'h1);
        step_a(1'b1, 1'b0, 4'h2);
        check("s4_count2", 32'(bus_a.count), 32'd2);
        step_a(1'b0, 1'b1, 4'h0);
        check("s4_count0",  32'(bus_a.count),  32'd0);
        check("s4_loaded0", 32'(bus_a.loaded), 32'd0);
        check("s4_ready",   32'(bus_a.ready),  32'd1);
        step_a(1'b1, 1'b0, 4'h4);
        step_a(1'b1, 1'b0, 4'h6);
        check("s4_notfull", 32'(bus_a.loaded), 32'd0);
        step_a(1'b1, 1'b0, 4'h8);
        check("s4_loaded", 32'(bus_a.loaded),  32'd1);
        check("s4_regout", 32'(bus_a.reg_out), 32'h864);

        // Release without load
        step_a(1'b0, 1'b1, 4'h0);
        check("s4_rel_count",  32'(bus_a.count),  32'd0);
        check("s4_rel_loaded", 32'(bus_a.loaded), 32'd0);
`ifdef OPERAND_BANK_CLR_ON_DONE_EN
        check("s4_rel_regout", 32'(bus_a.reg_out), 32'h000);
`else
        check("s4_rel_regout", 32'(bus_a.reg_out), 32'h864);
`endif

        // Reset mid-fill
        step_a(1'b1, 1'b0, 4'h9);
        step_a(1'b1, 1'b0, 4'hB);
        check("s5_pre_count", 32'(bus_a.count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("s5_count",  32'(bus_a.count),   32'd0);
        check("s5_loaded", 32'(bus_a.loaded),  32'd0);
        check("s5_regout", 32'(bus_a.reg_out), 32'h000);
        check("s5_err",    32'(bus_a.err_ovf), 32'd0);

        // done+load during FILL restarts at slot 0
        step_a(1'b1, 1'b0, 4'h1);
        step_a(1'b1, 1'b1, 4'hD);
        check("fd_count",  32'(bus_a.count),   32'd1);
        check("fd_loaded", 32'(bus_a.loaded),  32'd0);
        check("fd_regout", 32'(bus_a.reg_out), 32'h00D);

        // Single-operand bank
        check("s6_b_rst", 32'(bus_b.loaded), 32'd0);
        step_b(1'b1, 1'b0, 8'hC3);
        check("s6_loaded", 32'(bus_b.loaded),  32'd1);
        check("s6_regout", 32'(bus_b.reg_out), 32'hC3);
        check("s6_count",  32'(bus_b.count),   32'd1);
        check("s6_ready",  32'(bus_b.ready),   32'd0);
        step_b(1'b1, 1'b1, 8'h3C);
        check("s6_b2b_loaded", 32'(bus_b.loaded),  32'd1);
        check("s6_b2b_regout", 32'(bus_b.reg_out), 32'h3C);
        check("s6_b2b_err",    32'(bus_b.err_ovf), 32'd0);
        step_b(1'b1, 1'b0, 8'h55);
        check("s6_ovf_err",    32'(bus_b.err_ovf), 32'd1);
        check("s6_ovf_regout", 32'(bus_b.reg_out), 32'h3C);
        step_b(1'b0, 1'b1, 8'h00);
        check("s6_rel_loaded", 32'(bus_b.loaded), 32'd0);
        check("s6_rel_count",  32'(bus_b.count),  32'd0);
        check("s6_rel_ready",  32'(bus_b.ready),  32'd1);
`ifdef OPERAND_BANK_CLR_ON_DONE_EN
        check("s6_rel_regout", 32'(bus_b.reg_out), 32'h00);
`else
        check("s6_rel_regout", 32'(bus_b.reg_out), 32'h3C);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
`default_nettype wire
